// File: rtl/scan_config_loader.sv
// Serialises host configuration words into the fabric scan chain using generated scan_clk/scan_en/scan_in.
// Optional readback of the previous chain contents is enabled with `define SCAN_READBACK_EN.
module scan_config_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              scan_clk,
  output logic              scan_en,
  output logic              scan_in,
  input  logic              scan_ret,
  output logic              busy,
  output logic              done
`ifdef SCAN_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  // state     | meaning
  // IDLE      | outputs low, waiting for start
  // WAIT_WORD | cfg_ready high, scan_clk low, waiting for a host word
  // SHIFT_LO  | present shreg MSB on scan_in, scan_clk low
  // SHIFT_HI  | scan_clk high, chain captures scan_in
  // DONE      | one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE,
    WAIT_WORD,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int CW = $clog2(WORD_W + 1);

  state_t            state, nstate;
  logic [BW-1:0]     bits_done;
  logic [CW-1:0]     wcnt;
  logic [CW-1:0]     wcnt_load;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic              load_word, shift;
  int                rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate    = state;
    load_word = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE:      if (start) nstate = WAIT_WORD;
      WAIT_WORD: begin
        if (cfg_valid && cfg_ready) begin
          load_word = 1'b1;
          nstate    = SHIFT_LO;
        end
      end
      SHIFT_LO:  nstate = SHIFT_HI;
      SHIFT_HI: begin
        shift = 1'b1;
        if (bits_done == BW'(CHAIN_LEN - 1)) nstate = DONE;
        else if (wcnt == CW'(1))             nstate = WAIT_WORD;
        else                                 nstate = SHIFT_LO;
      end
      DONE:      nstate = IDLE;
      default:   nstate = IDLE;
    endcase
  end

  // The last word only carries the bits still missing from the chain.
  always_comb begin
    rem = CHAIN_LEN - int'(bits_done);
    if (rem < WORD_W) wcnt_load = CW'(rem);
    else              wcnt_load = CW'(WORD_W);
  end

  always_comb begin
    shreg_nxt = shreg;
    if (load_word)  shreg_nxt = cfg_data;
    else if (shift) shreg_nxt = shreg << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_done <= '0;
      wcnt      <= '0;
      shreg     <= '0;
    end else begin
      shreg <= shreg_nxt;
      if (state == IDLE && start) begin
        bits_done <= '0;
        wcnt      <= '0;
      end else if (load_word) begin
        wcnt <= wcnt_load;
      end else if (shift) begin
        bits_done <= bits_done + BW'(1);
        wcnt      <= wcnt - CW'(1);
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready <= 1'b0;
      scan_clk  <= 1'b0;
      scan_en   <= 1'b0;
      scan_in   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cfg_ready <= (nstate == WAIT_WORD);
      scan_clk  <= (nstate == SHIFT_HI);
      scan_en   <= (nstate == WAIT_WORD) || (nstate == SHIFT_LO) || (nstate == SHIFT_HI);
      busy      <= (nstate != IDLE);
      done      <= (nstate == DONE);
      if (nstate == IDLE)          scan_in <= 1'b0;
      else if (nstate == SHIFT_LO) scan_in <= shreg_nxt[WORD_W-1];
    end
  end

`ifdef SCAN_READBACK_EN
  logic [WORD_W-1:0] rb_sh, rb_sh_nxt;
  logic [CW-1:0]     rb_cnt;

  assign rb_sh_nxt = {rb_sh[WORD_W-2:0], scan_ret};

  // The tail bit is captured on the edge that raises scan_clk, before the chain shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_sh    <= '0;
      rb_cnt   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state == IDLE && start) begin
        rb_sh  <= '0;
        rb_cnt <= '0;
      end else if (state == SHIFT_LO) begin
        if (rb_cnt == CW'(WORD_W - 1)) begin
          rb_data  <= rb_sh_nxt;
          rb_valid <= 1'b1;
          rb_sh    <= '0;
          rb_cnt   <= '0;
        end else begin
          rb_sh  <= rb_sh_nxt;
          rb_cnt <= rb_cnt + CW'(1);
        end
      end else if (nstate == DONE && rb_cnt != '0) begin
        rb_data  <= rb_sh << (CW'(WORD_W) - rb_cnt);
        rb_valid <= 1'b1;
        rb_sh    <= '0;
        rb_cnt   <= '0;
      end else if (nstate == IDLE) begin
        rb_data <= '0;
      end
    end
  end
`else
  logic unused_scan_ret;
  assign unused_scan_ret = scan_ret;
`endif

endmodule

// File: tb/tb_scan_config_loader.sv
// Directed bench for scan_config_loader with a behavioural 20-bit chain model.
// Define SCAN_READBACK_EN to also exercise the readback path.
module tb_scan_config_loader;
  localparam int CL = 20;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         scan_clk, scan_en, scan_in;
  logic         scan_ret;
  logic         busy, done;
`ifdef SCAN_READBACK_EN
  logic [W-1:0] rb_data;
  logic         rb_valid;
`endif

  scan_config_loader #(.CHAIN_LEN(CL), .WORD_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .scan_clk  (scan_clk),
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .scan_ret  (scan_ret),
    .busy      (busy),
    .done      (done)
`ifdef SCAN_READBACK_EN
    ,
    .rb_data   (rb_data),
    .rb_valid  (rb_valid)
`endif
  );

  always #5 clk = ~clk;

  int          n_tot = 0;
  int          n_bad = 0;
  int          cyc, widx, nw, nrise, ndone, gap_left, rbn, dcyc;
  logic [CL-1:0] chain;
  logic [W-1:0]  wq [4];
  logic [W-1:0]  rbq [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: track handshakes, scan_clk rises (chain model), done/readback pulses, then drive the host.
  task automatic tick;
    logic acc, pclk;
    acc  = cfg_valid && cfg_ready;
    pclk = scan_clk;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) widx++;
    if (!pclk && scan_clk) begin
      nrise++;
      chain = {chain[CL-2:0], scan_in};
    end
    scan_ret = chain[CL-1];
    if (done) ndone++;
`ifdef SCAN_READBACK_EN
    if (rb_valid && rbn < 8) begin
      rbq[rbn] = rb_data;
      rbn++;
    end
`endif
    cfg_data = (widx < 4) ? wq[widx] : '0;
    if (widx == 1 && cfg_ready && gap_left > 0) begin
      cfg_valid = 1'b0;
      gap_left--;
      check("gap_scan_clk", {31'd0, scan_clk}, 32'd0);
      check("gap_scan_en", {31'd0, scan_en}, 32'd1);
    end else begin
      cfg_valid = (widx < nw);
    end
  endtask

  task automatic do_load(input int words, input int gap, input int spulse, input int abort_at);
    widx = 0; nw = words; nrise = 0; ndone = 0; rbn = 0; gap_left = gap; dcyc = -1;
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    check("ready_after_start", {31'd0, cfg_ready}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      if (abort_at >= 0 && cyc == abort_at) return;
      start = (cyc == spulse);
      tick();
      if (dcyc >= 0) check("ready_after_done", {31'd0, cfg_ready}, 32'd0);
      if (done && dcyc < 0) dcyc = cyc;
      if (dcyc >= 0 && cyc >= dcyc + 6) break;
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    if (dcyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_outs"}, {26'd0, cfg_ready, scan_clk, scan_en, scan_in, busy, done}, 32'd0);
`ifdef SCAN_READBACK_EN
    check({tag, "_rb"}, {23'd0, rb_valid, rb_data}, 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_data = '0; cfg_valid = 1'b0;
    chain = '0; scan_ret = 1'b0; cyc = 0; widx = 0; nw = 0; gap_left = 0;
    wq[0] = 8'hA5; wq[1] = 8'h3C; wq[2] = 8'hF0; wq[3] = 8'h55;
    #12;
    check_outs_zero("reset");
    rst_n = 1'b1;
    tick();
    check_outs_zero("idle");

    // full load
    do_load(3, 0, -1, -1);
    check("full_chain", 32'(chain), 32'h000A53CF);
    check("full_done_cyc", 32'(dcyc), 32'd43);
    check("full_rises", 32'(nrise), 32'd20);
    check("full_words", 32'(widx), 32'd3);
    check("full_ndone", 32'(ndone), 32'd1);
    check("full_busy_after", {31'd0, busy}, 32'd0);

    // stall before the second word
    chain = '0; scan_ret = 1'b0;
    do_load(3, 10, -1, -1);
    check("stall_chain", 32'(chain), 32'h000A53CF);
    check("stall_done_cyc", 32'(dcyc), 32'd53);
    check("stall_rises", 32'(nrise), 32'd20);

    // start pulsed during a running load
    chain = '0; scan_ret = 1'b0;
    do_load(3, 0, 5, -1);
    check("sig_words", 32'(widx), 32'd3);
    check("sig_ndone", 32'(ndone), 32'd1);
    check("sig_done_cyc", 32'(dcyc), 32'd43);
    check("sig_chain", 32'(chain), 32'h000A53CF);

    // fourth word offered after the last one
    chain = '0; scan_ret = 1'b0;
    do_load(4, 0, -1, -1);
    check("extra_words", 32'(widx), 32'd3);
    check("extra_chain", 32'(chain), 32'h000A53CF);
    check("extra_ndone", 32'(ndone), 32'd1);

    // reset during SHIFT_HI of bit 7
    do_load(3, 0, -1, 14);
    check("mid_in_shift_hi", {31'd0, scan_clk}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_outs_zero("mid_reset");
    cfg_valid = 1'b0;
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check_outs_zero("post_reset");
    wq[0] = 8'h5A; wq[1] = 8'hC3; wq[2] = 8'h0F;
    do_load(3, 0, -1, -1);
    check("fresh_chain", 32'(chain), 32'h0005AC30);
    check("fresh_done_cyc", 32'(dcyc), 32'd43);

`ifdef SCAN_READBACK_EN
    // readback of a chain preloaded with all ones
    chain = 20'hFFFFF; scan_ret = 1'b1;
    wq[0] = 8'h00; wq[1] = 8'h00; wq[2] = 8'h00;
    do_load(3, 0, -1, -1);
    check("rb_count", 32'(rbn), 32'd3);
    check("rb_w0", {24'd0, rbq[0]}, 32'hFF);
    check("rb_w1", {24'd0, rbq[1]}, 32'hFF);
    check("rb_w2", {24'd0, rbq[2]}, 32'hF0);
    check("rb_chain", 32'(chain), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_config_loader.md
# scan_config_loader

- Bitstream loader that sits directly upstream of the fabric's scan-programmed configuration chain, which is made of connection-block routing ROMs chained scan_out→scan_in.
- Accepts configuration words from a host over a valid/ready handshake.
- Serialises exactly CHAIN_LEN bits into the chain, generating scan_clk, scan_en and scan_in from the system clock.
- Pulses done when the chain is fully programmed; can optionally return the previous chain contents as readback words.

## Interface
- CHAIN_LEN, default 20: total configuration bits in the chain; ≥1.
- WORD_W, default 8: host word width; ≥2.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  load request; sampled only in IDLE.
- cfg_data  in  WORD_W  configuration word; the MSB is shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader accepts a word this cycle.
- scan_clk  out  1  chain shift clock (registered); the chain samples on its rising edge.
- scan_en  out  1  chain shift enable (registered).
- scan_in  out  1  serial data to the chain head (registered).
- scan_ret  in  1  scan_out of the chain tail.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when CHAIN_LEN bits have been shifted.
- rb_data  out  WORD_W  readback word (SCAN_READBACK_EN only).
- rb_valid  out  1  one-cycle readback strobe (SCAN_READBACK_EN only).

## Operation
- States: IDLE, WAIT_WORD, SHIFT_LO, SHIFT_HI, DONE.
- IDLE
  - All outputs are 0.
  - start=1 → WAIT_WORD, with the bit counter and the word bit counter cleared.
- WAIT_WORD
  - cfg_ready=1, scan_en=1, scan_clk=0; scan_in holds its last value.
  - On cfg_valid&&cfg_ready: latch cfg_data into the shift register.
  - Load the word bit count with min(WORD_W, CHAIN_LEN−bits_done), then go to SHIFT_LO.
  - With cfg_valid low the block stalls indefinitely; scan_clk stays low.
- SHIFT_LO
  - scan_clk=0, scan_en=1, scan_in=shreg MSB. Next state is SHIFT_HI.
- SHIFT_HI
  - scan_clk=1; scan_in is held unchanged.
  - The shift register shifts left, bits_done increments and the word bit count decrements.
  - Next state: DONE if bits_done==CHAIN_LEN; else WAIT_WORD if the word is exhausted; else SHIFT_LO.
- DONE
  - done=1, busy=1, scan_en=0, scan_clk=0, cfg_ready=0. Next state is IDLE.
- Last word: only its top (CHAIN_LEN mod WORD_W) bits are shifted when that value is nonzero; the remaining low bits are discarded.
  - Example: CHAIN_LEN=20, WORD_W=8 → 3 words, and only bits [7:4] of the third word are used.
- Chain ordering: the first bit shifted ends up at the tail ROM's MSB. The host orders the bitstream accordingly; the loader does no reordering.
- Words offered after the last one are not accepted (cfg_ready=0 outside WAIT_WORD).

## Timing
- Reset: state IDLE. scan_clk, scan_en, scan_in, cfg_ready, busy, done, rb_valid and rb_data are all 0.
- Reset mid-load returns immediately to IDLE; chain contents are undefined and the host must restart.
- start=1 outside IDLE is ignored; there is no queuing.
- Per bit: 2 clk cycles.
  - scan_in is stable for one full clk before the scan_clk rise.
  - scan_in is held through the high phase.
- Per word: 1 handshake cycle minimum.
- cfg_ready is high in the cycle after start is sampled.
- Example: CHAIN_LEN=20, WORD_W=8, cfg_valid held high.
  - Words are accepted at edges 1, 18 and 35 after the start edge (edge 0).
  - done is high during the cycle following edge 43.
  - Exactly 20 scan_clk rising edges occur.
- busy falls in the cycle after done.
- start is sampled only in IDLE, so a start coincident with done is ignored. A new load begins with a start sampled in IDLE on or after the edge that follows the done cycle.

## Configuration
- SCAN_READBACK_EN defined:
  - scan_ret is sampled on the clk edge that raises scan_clk, i.e. the old tail bit before the shift.
  - Sampled bits are packed MSB-first into rb_data.
  - rb_valid pulses for one cycle each time WORD_W bits are collected.
  - At DONE, a final partial word is emitted left-justified and zero-filled.
  - There is no backpressure on readback.
- SCAN_READBACK_EN undefined: rb_data and rb_valid ports are absent and scan_ret is ignored.

## Test plan
- Full load
  - Stimulus: CHAIN_LEN=20, WORD_W=8, words 0xA5, 0x3C, 0xF0 with cfg_valid held; a 20-bit shift-register model is on the chain.
  - Required: the model holds bits 1010_0101_0011_1100_1111 in shift order; done is high 43 cycles after start; 20 scan_clk rising edges.
- Stall
  - Stimulus: drop cfg_valid for 10 cycles before the second word.
  - Required: scan_clk stays 0, scan_en stays 1 and cfg_ready stays 1 during the gap; the final chain contents are identical; done is 10 cycles later.
- Start ignored
  - Stimulus: pulse start at cycle 5 of a running load.
  - Required: no restart; exactly 3 words are consumed and one done pulse occurs.
- Reset mid-operation
  - Stimulus: assert rst_n=0 in SHIFT_HI of bit 7.
  - Required: all outputs are 0 asynchronously; after release busy=0 and the loader is in IDLE; a fresh load completes correctly.
- Readback (SCAN_READBACK_EN)
  - Stimulus: preload the chain model with 20'hFFFFF, then load all zeros.
  - Required: rb_data sequence 0xFF, 0xFF, 0xF0, each with a one-cycle rb_valid.
- Extra words
  - Stimulus: cfg_valid held high with a 4th word after the 3rd word.
  - Required: the 4th word is never accepted; cfg_ready=0 from DONE onward.
